data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one load/store at a time,
// fixed access latency, response returned over a second valid/ready handshake.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned WORD_BITS = ADDR_WIDTH - 3;
    localparam int unsigned DEPTH     = 1 << WORD_BITS;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [63:0]          wdata_q, wdata_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [63:0]          resp_rdata_q, resp_rdata_d;
    logic                 resp_err_q, resp_err_d;
    logic                 mem_we;
    logic                 addr_err;
    logic [63:0]          mem_q [DEPTH];

    // Misaligned or beyond the implemented byte range.
    assign addr_err = (req_addr[2:0] != 3'b000) || (req_addr[63:ADDR_WIDTH] != '0);

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        err_d        = err_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    err_d       = addr_err;
                    word_d      = req_addr[ADDR_WIDTH-1:3];
                    wdata_d     = req_wdata;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Errored requests touch no memory but still take the full latency.
                    mem_we       = write_q && !err_q;
                    resp_rdata_d = (write_q || err_q) ? 64'd0 : mem_q[word_q];
                    resp_err_d   = err_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 64'd0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            word_q       <= '0;
            wdata_q      <= 64'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            err_q        <= err_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array is deliberately not reset so committed stores survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_q] <= wdata_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses LATENCY=2,
// instances 1 and 2 use LATENCY=1 and LATENCY=15.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset;

    logic [2:0]       req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [2:0][63:0] req_addr, req_wdata, resp_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    int          lat;
    int          nacc, nresp, cyc;
    int          acc_cyc [4];
    logic [63:0] got     [4];
    logic [63:0] addrs   [4];
    logic        rr;
    int          lat_exp [3];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Present one request (instance must be idle), then count edges until resp_valid.
    task automatic issue(input int k, input logic w, input logic [63:0] a,
                         input logic [63:0] d, output int l);
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        l = 0;
        while (resp_valid[k] !== 1'b1 && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic consume(input int k, input string tag);
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        check({tag, "_valid_clr"}, 64'(resp_valid[k]), 64'd0);
        check({tag, "_ready_set"}, 64'(req_ready[k]), 64'd1);
        check({tag, "_rdata_clr"}, resp_rdata[k], 64'd0);
        check({tag, "_err_clr"}, 64'(resp_err[k]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lat_exp[0] = 2; lat_exp[1] = 1; lat_exp[2] = 15;
        addrs[0] = 64'h000; addrs[1] = 64'h008; addrs[2] = 64'h010; addrs[3] = 64'h3F8;
        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        resp_ready = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready[0]), 64'd1);
        check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("rst_resp_rdata", resp_rdata[0], 64'd0);
        check("rst_resp_err", 64'(resp_err[0]), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Store then load.
        check("t1_ready", 64'(req_ready[0]), 64'd1);
        issue(0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, lat);
        check("t1_st_lat", 64'(lat), 64'd2);
        check("t1_st_err", 64'(resp_err[0]), 64'd0);
        check("t1_st_rdata", resp_rdata[0], 64'd0);
        consume(0, "t1_st");
        issue(0, 1'b0, 64'h18, 64'd0, lat);
        check("t1_ld_lat", 64'(lat), 64'd2);
        check("t1_ld_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
        check("t1_ld_err", 64'(resp_err[0]), 64'd0);
        consume(0, "t1_ld");

        // Backpressure; a request held during RESP must be ignored.
        issue(0, 1'b0, 64'h18, 64'd0, lat);
        check("t2_lat", 64'(lat), 64'd2);
        req_write[0] = 1'b1;
        req_addr[0]  = 64'h18;
        req_wdata[0] = 64'h0BAD;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(resp_valid[0]), 64'd1);
            check("t2_hold_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
            check("t2_hold_err", 64'(resp_err[0]), 64'd0);
            check("t2_hold_ready", 64'(req_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        consume(0, "t2");

        // Errors: misaligned store aliasing word 3, then out-of-range load.
        issue(0, 1'b1, 64'h1C, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        check("t3_mis_lat", 64'(lat), 64'd2);
        check("t3_mis_err", 64'(resp_err[0]), 64'd1);
        check("t3_mis_rdata", resp_rdata[0], 64'd0);
        consume(0, "t3_mis");
        issue(0, 1'b0, 64'h18, 64'd0, lat);
        check("t3_intact_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
        consume(0, "t3_intact");
        issue(0, 1'b0, 64'h400, 64'd0, lat);
        check("t3_oor_lat", 64'(lat), 64'd2);
        check("t3_oor_err", 64'(resp_err[0]), 64'd1);
        check("t3_oor_rdata", resp_rdata[0], 64'd0);
        consume(0, "t3_oor");

        // Back-to-back loads with req_valid and resp_ready held high.
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, addrs[i], 64'(i + 1), lat);
            consume(0, "t4_pre");
        end
        nacc = 0; nresp = 0; cyc = 0;
        resp_ready[0] = 1'b1;
        req_write[0]  = 1'b0;
        req_addr[0]   = addrs[0];
        req_valid[0]  = 1'b1;
        rr = req_ready[0];
        while (nresp < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (rr && req_valid[0]) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 4) req_addr[0] = addrs[nacc];
                else req_valid[0] = 1'b0;
            end
            if (resp_valid[0]) begin
                got[nresp] = resp_rdata[0];
                nresp++;
            end
            rr = req_ready[0];
        end
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        check("t4_nresp", 64'(nresp), 64'd4);
        check("t4_nacc", 64'(nacc), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t4_rdata", got[i], 64'(i + 1));
        end
        // Accept-to-accept: LATENCY cycles, the handshake edge, then the re-armed accept.
        for (int i = 0; i < 3; i++) begin
            check("t4_gap", 64'(acc_cyc[i+1] - acc_cyc[i]), 64'd4);
        end
        check("t4_idle_ready", 64'(req_ready[0]), 64'd1);

        // Reset while a store is BUSY: store is discarded.
        issue(0, 1'b1, 64'h20, 64'hAAAA_0000_1111_BBBB, lat);
        consume(0, "t5_pre");
        req_write[0] = 1'b1;
        req_addr[0]  = 64'h20;
        req_wdata[0] = 64'h55;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("t5_busy_ready", 64'(req_ready[0]), 64'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t5_async_ready", 64'(req_ready[0]), 64'd1);
        check("t5_async_valid", 64'(resp_valid[0]), 64'd0);
        @(posedge clk); #1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        issue(0, 1'b0, 64'h20, 64'd0, lat);
        check("t5_old_rdata", resp_rdata[0], 64'hAAAA_0000_1111_BBBB);

        // Reset while in RESP: response dropped immediately.
        #2;
        reset = 1'b1;
        #1;
        check("t5_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("t5_resp_rdata", resp_rdata[0], 64'd0);
        check("t5_resp_ready", 64'(req_ready[0]), 64'd1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        issue(0, 1'b0, 64'h18, 64'd0, lat);
        check("t5_survive_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
        consume(0, "t5_post");

        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        for (int k = 1; k < 3; k++) begin
            check("t6_ready", 64'(req_ready[k]), 64'd1);
            issue(k, 1'b1, 64'h8, 64'h77 + 64'(k), lat);
            check("t6_st_lat", 64'(lat), 64'(lat_exp[k]));
            check("t6_st_rdata", resp_rdata[k], 64'd0);
            consume(k, "t6_st");
            issue(k, 1'b0, 64'h8, 64'd0, lat);
            check("t6_ld_lat", 64'(lat), 64'(lat_exp[k]));
            check("t6_ld_rdata", resp_rdata[k], 64'h77 + 64'(k));
            consume(k, "t6_ld");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
